counter_readback: RTL
=====================

# counter_readback

Reads back the four external negative-edge counter ICs that are clocked and reset by the tester's counter-control logic. It synchronizes their parallel outputs, waits for the ICs to settle after any advance or reset, and captures a stable snapshot. The snapshot is delivered to the test sequencer over a valid/ack handshake, optionally flagged against a locally tracked expected count. It sits beside the counter-control block and taps the same ADVANCE_COUNTER and RESET_COUNTER strobes.

## Interface
- WIDTH, 8: bits per counter IC.
- SETTLE, 4: cycles to wait after a request or counter event before sampling; must be at least 1.
- STABLE, 2: number of consecutive identical synchronized samples required to accept a snapshot; must be at least 1.
- CLK  in  1  system clock (100 MHz).
- RST  in  1  reset, synchronous, active-high; clock CLK.
- ADVANCE_COUNTER  in  1  advance strobe, the same signal that drives counter control; may be held for several cycles.
- RESET_COUNTER  in  1  reset strobe, the same signal that drives counter control; may be held for several cycles.
- CNT_Q_1..CNT_Q_4  in  WIDTH each  asynchronous IC outputs.
- READ_REQ  in  1  snapshot request; sampled only in IDLE.
- DATA_ACK  in  1  consumer has taken the snapshot.
- DATA_OUT  out  4*WIDTH  snapshot {Q_4,Q_3,Q_2,Q_1}, with Q_1 in the LSBs.
- DATA_VALID  out  1  snapshot valid; held until acknowledged.
- MISMATCH  out  4  per-IC compare failure; bit n-1 corresponds to IC n.
- TIMEOUT  out  1  bus never reached stability.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: every CNT_Q bit passes through 2 flops. There is no reset on these flops.
- Event detect: an event is a rising edge of ADVANCE_COUNTER or RESET_COUNTER, registered against the previous cycle's value.
- FSM states and transitions:
  - IDLE: READ_REQ=1 loads the settle counter with SETTLE and moves to SETTLE.
  - SETTLE: the settle counter decrements each cycle. Any event reloads it to SETTLE. When it reaches 0, clear the stable count and go to SAMPLE.
  - SAMPLE: each cycle, compare the synchronized bus with the previous sample.
    - The first sample in SAMPLE, or a sample that differs from the previous one, sets the stable count to 1.
    - A sample equal to the previous one increments the stable count.
    - When the stable count equals STABLE, latch the sample into DATA_OUT and go to CHECK.
    - Any event returns the FSM to SETTLE with the settle counter reloaded.
    - After 16 SAMPLE cycles without acceptance, latch the last sample, set TIMEOUT=1 and go to DONE.
  - CHECK: takes 1 cycle. Compute MISMATCH, then go to DONE.
  - DONE: DATA_VALID=1. It stays high until DATA_ACK=1 is sampled; on that cycle go to IDLE and clear DATA_VALID.
- DATA_OUT, MISMATCH and TIMEOUT hold their values until the next capture. They are cleared when the FSM enters SETTLE from IDLE.
- Events arriving while in DONE or IDLE update only the expected model; they do not change the FSM state.
- READ_REQ outside IDLE is ignored and not queued.

## Timing
- Reset values: DATA_OUT=0, DATA_VALID=0, MISMATCH=0, TIMEOUT=0, BUSY=0, state=IDLE, expected=0.
- Cycle numbering: READ_REQ is sampled at cycle 0.
  - BUSY goes high at cycle 1.
  - SETTLE occupies cycles 1..SETTLE.
  - SAMPLE starts at cycle SETTLE+1.
- Minimum latency to DATA_VALID, with a quiet and stable bus, is SETTLE+STABLE+2 cycles. With default parameters that is cycle 8.
- DATA_VALID falls the cycle after DATA_ACK is sampled. A new READ_REQ is accepted one cycle after that, once the FSM is back in IDLE.
- RST asserted in any state takes effect on the next edge: all outputs return to their reset values and any snapshot in flight is discarded.

## Configuration
- COUNTER_READBACK_CHECK_EN defined:
  - An expected-count register of WIDTH bits is built.
  - A RESET_COUNTER edge sets it to 0.
  - An ADVANCE_COUNTER edge increments it, wrapping modulo 2^WIDTH.
  - If both edges occur in the same cycle, the advance wins, matching counter-control priority.
  - In CHECK, MISMATCH[n-1] = (Q_n != expected).
- Not defined: there is no expected register, MISMATCH is constant 0, and CHECK still occupies its 1 cycle.

## Test plan
- Reset, then READ_REQ with all CNT_Q=8'h00 held steady: DATA_VALID rises at cycle 8, DATA_OUT=32'h0, MISMATCH=0, TIMEOUT=0.
- With the check macro defined: 3 ADVANCE_COUNTER pulses of 4 cycles each, with the bus model showing 8'h03 on all ICs, then READ_REQ: DATA_OUT=32'h03030303, MISMATCH=4'b0000. Repeat with Q_3=8'h02: MISMATCH=4'b0100.
- With the check macro defined: 256 advances followed by a read with the bus at 8'h00: wrap-around yields MISMATCH=0. RESET_COUNTER and ADVANCE_COUNTER rising in the same cycle: expected becomes 1, not 0.
- ADVANCE_COUNTER edge at cycle 3 during SETTLE: the settle counter reloads and DATA_VALID moves out to cycle 11.
- Q_1 toggling every cycle for 20 cycles: TIMEOUT=1 and DATA_VALID rises after 16 SAMPLE cycles.
- RST pulsed while in DONE with DATA_VALID=1: all outputs read 0 on the next cycle, and a READ_REQ two cycles later is accepted normally.

Source files
------------

// File: rtl/counter_readback.sv
// counter_readback: synchronizes four counter IC outputs, waits for settling and a stable bus, then hands the snapshot over valid/ack.
// Optional feature macro COUNTER_READBACK_CHECK_EN adds the expected-count tracker and per-IC MISMATCH flags.
module counter_readback #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 4,
   parameter int STABLE = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ADVANCE_COUNTER,
   input  logic               RESET_COUNTER,
   input  logic [WIDTH-1:0]   CNT_Q_1,
   input  logic [WIDTH-1:0]   CNT_Q_2,
   input  logic [WIDTH-1:0]   CNT_Q_3,
   input  logic [WIDTH-1:0]   CNT_Q_4,
   input  logic               READ_REQ,
   input  logic               DATA_ACK,
   output logic [4*WIDTH-1:0] DATA_OUT,
   output logic               DATA_VALID,
   output logic [3:0]         MISMATCH,
   output logic               TIMEOUT,
   output logic               BUSY
);
   localparam int BW = 4*WIDTH;
   localparam int SW = $clog2(SETTLE+1);
   localparam int KW = $clog2(STABLE+1);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_CHECK, S_DONE} state_t;

   state_t          state, state_n;
   logic [BW-1:0]   sync_a, sync_b, prev, prev_n, data, data_n;
   logic [SW-1:0]   settle_cnt, settle_n;
   logic [KW-1:0]   stable_cnt, stable_n, run;
   logic [3:0]      samp_cnt, samp_n, mism, mism_n, mism_calc;
   logic            tout, tout_n, adv_d, rc_d, adv_ev, rc_ev, ev;

   // Asynchronous IC outputs: two-flop synchronizer, deliberately unreset
   always_ff @(posedge CLK) begin
      sync_a <= {CNT_Q_4, CNT_Q_3, CNT_Q_2, CNT_Q_1};
      sync_b <= sync_a;
      adv_d  <= ADVANCE_COUNTER;
      rc_d   <= RESET_COUNTER;
   end

   assign adv_ev = ADVANCE_COUNTER & ~adv_d;
   assign rc_ev  = RESET_COUNTER & ~rc_d;
   assign ev     = adv_ev | rc_ev;

`ifdef COUNTER_READBACK_CHECK_EN
   logic [WIDTH-1:0] expected;
   // Advance wins over reset when both strobes rise together
   always_ff @(posedge CLK) begin
      if (RST)
         expected <= '0;
      else if (adv_ev)
         expected <= expected + WIDTH'(1);
      else if (rc_ev)
         expected <= '0;
   end
   for (genvar i = 0; i < 4; i++) begin : g_mm
      assign mism_calc[i] = data[i*WIDTH +: WIDTH] != expected;
   end
`else
   assign mism_calc = '0;
`endif

   assign run = (samp_cnt == '0 || sync_b != prev) ? KW'(1) : stable_cnt + KW'(1);

   always_comb begin
      state_n  = state;
      settle_n = settle_cnt;
      stable_n = stable_cnt;
      samp_n   = samp_cnt;
      prev_n   = prev;
      data_n   = data;
      mism_n   = mism;
      tout_n   = tout;
      case (state)
         S_IDLE: if (READ_REQ) begin
            state_n  = S_SETTLE;
            settle_n = SW'(SETTLE);
            data_n   = '0;
            mism_n   = '0;
            tout_n   = 1'b0;
         end
         S_SETTLE: if (ev) settle_n = SW'(SETTLE);
            else if (settle_cnt == SW'(1)) begin
               state_n  = S_SAMPLE;
               stable_n = '0;
               samp_n   = '0;
            end else settle_n = settle_cnt - SW'(1);
         S_SAMPLE: if (ev) begin
            state_n  = S_SETTLE;
            settle_n = SW'(SETTLE);
         end else begin
            stable_n = run;
            prev_n   = sync_b;
            samp_n   = samp_cnt + 4'd1;
            if (run == KW'(STABLE)) begin
               data_n  = sync_b;
               state_n = S_CHECK;
            end else if (samp_cnt == 4'd15) begin
               data_n  = sync_b;
               tout_n  = 1'b1;
               state_n = S_DONE;
            end
         end
         S_CHECK: begin
            mism_n  = mism_calc;
            state_n = S_DONE;
         end
         S_DONE: if (DATA_ACK) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         stable_cnt <= '0;
         samp_cnt   <= '0;
         prev       <= '0;
         data       <= '0;
         mism       <= '0;
         tout       <= 1'b0;
      end else begin
         state      <= state_n;
         settle_cnt <= settle_n;
         stable_cnt <= stable_n;
         samp_cnt   <= samp_n;
         prev       <= prev_n;
         data       <= data_n;
         mism       <= mism_n;
         tout       <= tout_n;
      end
   end

   assign DATA_OUT   = data;
   assign DATA_VALID = state == S_DONE;
   assign MISMATCH   = mism;
   assign TIMEOUT    = tout;
   assign BUSY       = state != S_IDLE;
endmodule
